// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state type and
// operand-forwarding / writeback-select encodings.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    StRun     = 1'b0,
    StMemWait = 1'b1
  } state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  localparam logic [1:0] WB_MEM  = 2'b01;

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding select for one source register: the M result beats the W
// result, and x0 never forwards.
module fwd_sel
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] adr_i,
  input  logic [4:0] rd_m_i,
  input  logic       reg_write_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_w_i,
  output logic [1:0] fwd_o
);

  always_comb begin
    fwd_o = FWD_REG;
    if (reg_write_m_i && (rd_m_i == adr_i) && (rd_m_i != 5'd0)) begin
      fwd_o = FWD_M;
    end else if (reg_write_w_i && (rd_w_i == adr_i) && (rd_w_i != 5'd0)) begin
      fwd_o = FWD_W;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard controller for a D/M/W pipeline: operand forwarding, load-use stall,
// data-memory wait, redirect flush, and saturating stall/flush event counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       adr1D,
  input  logic [4:0]       adr2D,
  input  logic [4:0]       rdD,
  input  logic             reg_writeD,
  input  logic [1:0]       wb_selD,
  input  logic             mem_accessD,
  input  logic [1:0]       pc_selD,
  input  logic             mem_ready,
  output logic [1:0]       forward1D,
  output logic [1:0]       forward2D,
  output logic             stallF,
  output logic             stallD,
  output logic             stallM,
  output logic             bubbleM,
  output logic             bubbleW,
  output logic             flushD,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e           state_q, state_d;
  logic [4:0]       rd_m_q, rd_m_d;
  logic             reg_write_m_q, reg_write_m_d;
  logic             load_m_q, load_m_d;
  logic             mem_m_q, mem_m_d;
  logic [4:0]       rd_w_q, rd_w_d;
  logic             reg_write_w_q, reg_write_w_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_stall, load_use, stall_any, flush;

  fwd_sel u_fwd_sel_1 (
    .adr_i         (adr1D),
    .rd_m_i        (rd_m_q),
    .reg_write_m_i (reg_write_m_q),
    .rd_w_i        (rd_w_q),
    .reg_write_w_i (reg_write_w_q),
    .fwd_o         (forward1D)
  );

  fwd_sel u_fwd_sel_2 (
    .adr_i         (adr2D),
    .rd_m_i        (rd_m_q),
    .reg_write_m_i (reg_write_m_q),
    .rd_w_i        (rd_w_q),
    .reg_write_w_i (reg_write_w_q),
    .fwd_o         (forward2D)
  );

  always_comb begin
    // An access in M that is not ready stalls already in RUN, and MEM_WAIT
    // keeps stalling through the cycle in which mem_ready rises.
    mem_stall = (state_q == StMemWait) || (mem_m_q && !mem_ready);
    load_use  = !mem_stall && load_m_q && (rd_m_q != 5'd0) &&
                ((rd_m_q == adr1D) || (rd_m_q == adr2D));
    stall_any = mem_stall || load_use;
    // pc_selD is a raw input, so gate it explicitly while reset is held.
    flush     = !rst && !stall_any && (pc_selD != 2'b00);
  end

  always_comb begin
    state_d       = state_q;
    rd_m_d        = rd_m_q;
    reg_write_m_d = reg_write_m_q;
    load_m_d      = load_m_q;
    mem_m_d       = mem_m_q;
    rd_w_d        = rd_w_q;
    reg_write_w_d = reg_write_w_q;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;

    unique case (state_q)
      StRun:     if (mem_m_q && !mem_ready) state_d = StMemWait;
      StMemWait: if (mem_ready) state_d = StRun;
      default:   state_d = StRun;
    endcase

    if (mem_stall) begin
      rd_w_d        = 5'd0;
      reg_write_w_d = 1'b0;
    end else begin
      rd_w_d        = rd_m_q;
      reg_write_w_d = reg_write_m_q;
      if (load_use) begin
        rd_m_d        = 5'd0;
        reg_write_m_d = 1'b0;
        load_m_d      = 1'b0;
        mem_m_d       = 1'b0;
      end else begin
        rd_m_d        = rdD;
        reg_write_m_d = reg_writeD;
        load_m_d      = (wb_selD == WB_MEM);
        mem_m_d       = mem_accessD;
      end
    end

    if (stall_any && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StRun;
      rd_m_q        <= 5'd0;
      reg_write_m_q <= 1'b0;
      load_m_q      <= 1'b0;
      mem_m_q       <= 1'b0;
      rd_w_q        <= 5'd0;
      reg_write_w_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      rd_m_q        <= rd_m_d;
      reg_write_m_q <= reg_write_m_d;
      load_m_q      <= load_m_d;
      mem_m_q       <= mem_m_d;
      rd_w_q        <= rd_w_d;
      reg_write_w_q <= reg_write_w_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign stallF    = stall_any;
  assign stallD    = stall_any;
  assign stallM    = mem_stall;
  assign bubbleM   = load_use;
  assign bubbleW   = mem_stall;
  assign flushD    = flush;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: load-use, forwarding, memory wait, redirect
// priority, counter saturation and asynchronous reset out of MEM_WAIT.
module tb_pipe_ctrl;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    adr1D, adr2D, rdD;
  logic          reg_writeD, mem_accessD, mem_ready;
  logic [1:0]    wb_selD, pc_selD;
  logic [1:0]    forward1D, forward2D;
  logic          stallF, stallD, stallM, bubbleM, bubbleW, flushD;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .adr1D       (adr1D),
    .adr2D       (adr2D),
    .rdD         (rdD),
    .reg_writeD  (reg_writeD),
    .wb_selD     (wb_selD),
    .mem_accessD (mem_accessD),
    .pc_selD     (pc_selD),
    .mem_ready   (mem_ready),
    .forward1D   (forward1D),
    .forward2D   (forward2D),
    .stallF      (stallF),
    .stallD      (stallD),
    .stallM      (stallM),
    .bubbleM     (bubbleM),
    .bubbleW     (bubbleW),
    .flushD      (flushD),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_d(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                       input logic rw, input logic [1:0] wb, input logic mem,
                       input logic [1:0] pcs);
    adr1D = a1; adr2D = a2; rdD = rd; reg_writeD = rw;
    wb_selD = wb; mem_accessD = mem; pc_selD = pcs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".stallF"}, {15'd0, stallF}, 16'd0);
    chk({tag, ".stallD"}, {15'd0, stallD}, 16'd0);
    chk({tag, ".stallM"}, {15'd0, stallM}, 16'd0);
    chk({tag, ".bubbleM"}, {15'd0, bubbleM}, 16'd0);
    chk({tag, ".bubbleW"}, {15'd0, bubbleW}, 16'd0);
    chk({tag, ".flushD"}, {15'd0, flushD}, 16'd0);
    chk({tag, ".fwd1"}, {14'd0, forward1D}, 16'd0);
    chk({tag, ".fwd2"}, {14'd0, forward2D}, 16'd0);
    chk({tag, ".stall_cnt"}, {12'd0, stall_cnt}, 16'd0);
    chk({tag, ".flush_cnt"}, {12'd0, flush_cnt}, 16'd0);
  endtask

  initial begin
    // Reset with a redirect and a matching D present: everything must read 0.
    rst = 1'b1; mem_ready = 1'b1;
    set_d(5'd5, 5'd5, 5'd5, 1'b1, 2'b01, 1'b1, 2'b01);
    #2;
    chk_quiet("reset");
    tick();
    rst = 1'b0;

    // lw x5 -> add x6,x5,x1: one load-use stall, then forward from W.
    set_d(5'd0, 5'd0, 5'd5, 1'b1, 2'b01, 1'b1, 2'b00);
    #1;
    chk("lw.stallF", {15'd0, stallF}, 16'd0);
    tick();
    set_d(5'd5, 5'd1, 5'd6, 1'b1, 2'b00, 1'b0, 2'b00);
    #1;
    chk("lu.stallF", {15'd0, stallF}, 16'd1);
    chk("lu.stallD", {15'd0, stallD}, 16'd1);
    chk("lu.bubbleM", {15'd0, bubbleM}, 16'd1);
    chk("lu.stallM", {15'd0, stallM}, 16'd0);
    tick();
    chk("lu2.stallF", {15'd0, stallF}, 16'd0);
    chk("lu2.bubbleM", {15'd0, bubbleM}, 16'd0);
    chk("lu2.fwd1", {14'd0, forward1D}, 16'd1);
    chk("lu2.fwd2", {14'd0, forward2D}, 16'd0);
    chk("lu2.stall_cnt", {12'd0, stall_cnt}, 16'd1);
    tick();

    // add x5 -> sub x7,x5,x5 with add x6 in W.
    set_d(5'd1, 5'd2, 5'd5, 1'b1, 2'b00, 1'b0, 2'b00);
    #1;
    chk("alu.fwd1_none", {14'd0, forward1D}, 16'd0);
    tick();
    set_d(5'd5, 5'd5, 5'd7, 1'b1, 2'b00, 1'b0, 2'b00);
    #1;
    chk("alu.fwd1_m", {14'd0, forward1D}, 16'd2);
    chk("alu.fwd2_m", {14'd0, forward2D}, 16'd2);
    chk("alu.stallF", {15'd0, stallF}, 16'd0);
    adr2D = 5'd6;
    #1;
    chk("alu.fwd2_w", {14'd0, forward2D}, 16'd1);
    adr2D = 5'd5;
    tick();
    // Writer of x0 goes to M, sub x7 is in W.
    set_d(5'd1, 5'd2, 5'd0, 1'b1, 2'b00, 1'b0, 2'b00);
    tick();
    set_d(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 2'b00);
    #1;
    chk("x0.fwd1", {14'd0, forward1D}, 16'd0);
    chk("x0.fwd2", {14'd0, forward2D}, 16'd0);
    adr1D = 5'd7;
    #1;
    chk("x0.fwd1_w7", {14'd0, forward1D}, 16'd1);
    adr1D = 5'd0;
    tick();

    // sw in M with mem_ready low for 3 cycles: 4 stall cycles.
    set_d(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b1, 2'b00);
    tick();
    set_d(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      chk($sformatf("mw%0d.stallM", i), {15'd0, stallM}, 16'd1);
      chk($sformatf("mw%0d.bubbleW", i), {15'd0, bubbleW}, 16'd1);
      chk($sformatf("mw%0d.stallF", i), {15'd0, stallF}, 16'd1);
      chk($sformatf("mw%0d.bubbleM", i), {15'd0, bubbleM}, 16'd0);
      tick();
    end
    #1;
    chk("mw.after_stallM", {15'd0, stallM}, 16'd0);
    chk("mw.stall_cnt", {12'd0, stall_cnt}, 16'd5);

    // Taken branch in D with a load-use hazard on rs1.
    set_d(5'd0, 5'd0, 5'd3, 1'b1, 2'b01, 1'b1, 2'b00);
    tick();
    set_d(5'd3, 5'd4, 5'd0, 1'b0, 2'b00, 1'b0, 2'b01);
    #1;
    chk("br.stallF", {15'd0, stallF}, 16'd1);
    chk("br.flushD_stall", {15'd0, flushD}, 16'd0);
    tick();
    chk("br.flushD", {15'd0, flushD}, 16'd1);
    chk("br.stallF2", {15'd0, stallF}, 16'd0);
    chk("br.flush_cnt0", {12'd0, flush_cnt}, 16'd0);
    tick();
    set_d(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 2'b00);
    #1;
    chk("br.flush_cnt1", {12'd0, flush_cnt}, 16'd1);
    chk("br.flushD_off", {15'd0, flushD}, 16'd0);
    chk("br.stall_cnt", {12'd0, stall_cnt}, 16'd6);
    tick();

    // Long memory wait drives stall_cnt past all-ones; it must hold at 15.
    set_d(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b1, 2'b00);
    tick();
    set_d(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 2'b01);
    mem_ready = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    chk("sat.stall_cnt", {12'd0, stall_cnt}, 16'd15);
    chk("sat.stallM", {15'd0, stallM}, 16'd1);
    chk("sat.flushD", {15'd0, flushD}, 16'd0);
    tick();
    chk("sat.stall_cnt_hold", {12'd0, stall_cnt}, 16'd15);

    // Reset mid-wait clears everything immediately and aborts the wait.
    rst = 1'b1;
    #1;
    chk_quiet("rst_mw");
    tick();
    rst = 1'b0;
    pc_selD = 2'b00;
    #1;
    chk("abort.stallM", {15'd0, stallM}, 16'd0);
    chk("abort.stallF", {15'd0, stallF}, 16'd0);
    tick();
    chk("abort.stall_cnt", {12'd0, stall_cnt}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the saturating event counters.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port adr1D  in  5  rs1 index of the instruction in D.
REQ-005 SHALL have port adr2D  in  5  rs2 index of the instruction in D.
REQ-006 SHALL have port rdD  in  5  rd index of the instruction in D.
REQ-007 SHALL have port reg_writeD  in  1  instruction in D writes rd.
REQ-008 SHALL have port wb_selD  in  2  writeback select of the instruction in D (WB_MEM marks a load).
REQ-009 SHALL have port mem_accessD  in  1  instruction in D accesses data memory.
REQ-010 SHALL have port pc_selD  in  2  PC select from D; non-zero means redirect.
REQ-011 SHALL have port mem_ready  in  1  data memory completes the access held in M this cycle.
REQ-012 SHALL have port forward1D  out  2  rs1 operand select: 00 regfile, 01 W result, 10 M ALU result.
REQ-013 SHALL have port forward2D  out  2  rs2 operand select, same encoding.
REQ-014 SHALL have port stallF  out  1  hold PC and the F/D register.
REQ-015 SHALL have port stallD  out  1  hold the D/M register inputs (D re-presents).
REQ-016 SHALL have port stallM  out  1  hold the M/W-bound state in M.
REQ-017 SHALL have port bubbleM  out  1  load a NOP into M at the next edge.
REQ-018 SHALL have port bubbleW  out  1  load a NOP into W at the next edge.
REQ-019 SHALL have port flushD  out  1  replace the F/D register with a NOP at the next edge.
REQ-020 SHALL have port stall_cnt  out  CNT_W  saturating count of stall cycles.
REQ-021 SHALL have port flush_cnt  out  CNT_W  saturating count of redirect flushes.

Function
REQ-022 SHALL keep shadow registers rdM, reg_writeM, loadM, memM, rdW and reg_writeW; in RUN without a load-use stall, D fields advance to M and M fields advance to W at each edge.
REQ-023 SHALL compute forwardN combinationally: 10 if reg_writeM and rdM==adrN and rdM!=0; else 01 if reg_writeW and rdW==adrN and rdW!=0; else 00. M has priority over W, and x0 never forwards.
REQ-024 SHALL assert a load-use stall when loadM and rdM!=0 and rdM matches adr1D or adr2D (conservative; no operand-use qualification).
REQ-025 During a load-use stall it SHALL drive stallF=stallD=1 and bubbleM=1, and clear the M shadows at the edge; the stall self-clears after one cycle.
REQ-026 SHALL implement the FSM states RUN and MEM_WAIT; RUN->MEM_WAIT when memM and !mem_ready; MEM_WAIT->RUN on mem_ready.
REQ-027 In MEM_WAIT it SHALL drive stallF=stallD=stallM=1 and bubbleW=1; M shadows hold and W shadows clear.
REQ-028 The cycle in which mem_ready rises SHALL stall, and the pipeline advances at the following edge.
REQ-029 Priority SHALL be memory wait > load-use > redirect; flushD=1 only when pc_selD!=0 in RUN with no load-use stall.
REQ-030 stall_cnt SHALL increment on each cycle with stallF=1; flush_cnt SHALL increment on each flushD=1 cycle; both saturate at all-ones.

Reset
REQ-031 While rst is high: state=RUN, all shadows 0, counters 0, all stall/bubble/flush outputs 0, and forward1D=forward2D=00.
REQ-032 Reset asserted mid-MEM_WAIT SHALL abort the wait immediately, without waiting for mem_ready.

Structure
REQ-033 The FSM state type, forward encodings (FWD_REG/FWD_W/FWD_M) and WB_MEM=2'b01 SHALL reside in the shared defines package.
REQ-034 The forwarding compare SHALL be one sub-module, fwd_sel, instantiated once per source operand.

Verification
REQ-035 lw x5 then add x6,x5,x1 -> one cycle stallF=stallD=bubbleM=1, then forward1D=01, stall_cnt=1.
REQ-036 add x5 then sub x7,x5,x5 -> forward1D=forward2D=10, no stall; rd=x0 variant -> 00.
REQ-037 sw in M with mem_ready low for 3 cycles -> MEM_WAIT, stallM=1 for 4 cycles, stall_cnt=4.
REQ-038 beq taken (pc_selD=01) with a load-use hazard on rs1 -> flushD=0 on the stall cycle, flushD=1 next cycle, flush_cnt=1.
REQ-039 rst pulse in MEM_WAIT -> all outputs 0 asynchronously, state RUN; counter forced to all-ones+1 stays saturated.
